// File: rtl/counter.sv
// Address counter: steps through 0..NUM_COUNT-1 once per enabled cycle,
// either wrapping back to 0 or stopping on the last value.
// count is registered, and valid is the combinational qualifier for the
// address presented in the current cycle.
module counter #(
    parameter int NUM_COUNT = 100,
    parameter int WRAP      = 1,
    localparam int CNT_W    = $clog2(NUM_COUNT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             valid
);

    // Catch illegal parameterisations at elaboration rather than in silicon.
    if (NUM_COUNT < 2 || NUM_COUNT > 65536) begin : g_bad_num_count
        $error("counter: NUM_COUNT=%0d outside legal range 2..65536", NUM_COUNT);
    end
    if (WRAP != 0 && WRAP != 1) begin : g_bad_wrap
        $error("counter: WRAP=%0d must be 0 or 1", WRAP);
    end

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(NUM_COUNT - 1);
    localparam bit               WRAP_EN = (WRAP == 1);

    // Set once the last value has been consumed in stop mode. It never sets
    // when wrapping, so it reduces to a constant 0 in that configuration.
    logic exhausted_q;

    // Advance count on every accepted cycle. Comparing against LAST, rather
    // than relying on natural overflow, keeps non-power-of-two ranges in
    // bounds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count       <= '0;
            exhausted_q <= 1'b0;
        end else if (enable && !exhausted_q) begin
            if (count == LAST) begin
                if (WRAP_EN) count <= '0;
                else         exhausted_q <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

    // The address is usable whenever it is requested and the range is not used up.
    assign valid = enable & ~exhausted_q;

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter. Three instances share one stimulus stream:
//   100 values wrapping, 5 values stopping, and 6 values wrapping.
// The reference model tracks only how many enabled cycles have occurred since
// reset, and it derives the expected address from that number arithmetically.
module tb_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [6:0] c100;
    logic [2:0] c5, c6;
    logic       v100, v5, v6;

    counter #(.NUM_COUNT(100), .WRAP(1)) u_c100 (
        .clk(clk), .reset(reset), .enable(enable), .count(c100), .valid(v100));
    counter #(.NUM_COUNT(5), .WRAP(0)) u_c5 (
        .clk(clk), .reset(reset), .enable(enable), .count(c5), .valid(v5));
    counter #(.NUM_COUNT(6), .WRAP(1)) u_c6 (
        .clk(clk), .reset(reset), .enable(enable), .count(c6), .valid(v6));

    always #5 clk = ~clk;

    typedef struct {
        int c0, c1, c2;
        bit v0, v1, v2;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   n_en   = 0;   // enabled cycles since the last reset

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected address: position n in the sequence, either modulo the range
    // or clamped to the last value.
    function automatic int exp_cnt(input int num, input bit wrap, input int n);
        if (wrap) return n % num;
        return (n < num) ? n : num - 1;
    endfunction

    function automatic bit exp_vld(input int num, input bit wrap, input int n, input bit en);
        return en && (wrap || n < num);
    endfunction

    // One cycle of stimulus: drive just after the rising edge and queue the
    // response that should be visible during this cycle.
    task automatic step(input bit en, input bit rst);
        exp_t e;
        @(posedge clk);
        #1;
        reset  = rst;
        enable = en;
        if (!rst) n_en = 0;
        e.c0 = exp_cnt(100, 1'b1, n_en); e.v0 = exp_vld(100, 1'b1, n_en, en);
        e.c1 = exp_cnt(5,   1'b0, n_en); e.v1 = exp_vld(5,   1'b0, n_en, en);
        e.c2 = exp_cnt(6,   1'b1, n_en); e.v2 = exp_vld(6,   1'b1, n_en, en);
        sb.push_back(e);
        if (en && rst) n_en++;
    endtask

    // Assert reset between edges and confirm the clear happens without a clock.
    task automatic do_reset();
        step(1'b0, 1'b0);
        #1;
        chk("async_reset c100", int'(c100), 0);
        chk("async_reset c5",   int'(c5),   0);
        chk("async_reset c6",   int'(c6),   0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
    endtask

    // Monitor: compare the DUT outputs against the oldest queued expectation
    // mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("c100 count", int'(c100), e.c0);
            chk("c100 valid", int'(v100), int'(e.v0));
            chk("c5 count",   int'(c5),   e.c1);
            chk("c5 valid",   int'(v5),   int'(e.v1));
            chk("c6 count",   int'(c6),   e.c2);
            chk("c6 valid",   int'(v6),   int'(e.v2));
        end
    end

    initial begin
        // Check the state held in reset first, then release.
        repeat (2) @(posedge clk);
        #2;
        chk("reset c100", int'(c100), 0);
        chk("reset v100", int'(v100), 0);
        step(1'b0, 1'b1);

        // Five enabled cycles, then hold with valid low.
        repeat (5) step(1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b1);

        // Split bursts resume from the held value.
        do_reset();
        repeat (3) step(1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b1);
        repeat (2) step(1'b1, 1'b1);

        // Wrap of the 100-entry counter; the 5-entry counter saturates, and
        // the 6-entry counter wraps repeatedly.
        do_reset();
        repeat (101) step(1'b1, 1'b1);
        step(1'b0, 1'b1);

        // Stop mode over a short range.
        do_reset();
        repeat (8) step(1'b1, 1'b1);

        // Abandon a sequence at 37, then restart from 0.
        do_reset();
        repeat (37) step(1'b1, 1'b1);
        do_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);

        // Randomised enable pattern with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(63) == 0) do_reset();
            else step($urandom_range(3) != 0, 1'b1);
        end
        step(1'b0, 1'b1);

        // Drain the scoreboard with a bounded wait.
        for (int t = 0; t < 20 && sb.size() > 0; t++) @(posedge clk);
        #6;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter NUM_COUNT, default 100: number of distinct count values, 0..NUM_COUNT-1; legal range 2..2^16.
REQ-003 Parameter WRAP, default 1: 1 = wrap after the last value, 0 = stop after the last value.
REQ-004 Derived constant CNT_W = $clog2(NUM_COUNT), local to the module, not overridable.
REQ-005 Port order SHALL be exactly clk, reset, enable, count, valid; instances connect positionally.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  asynchronous active-low reset.
REQ-008 enable  input  1  advance request; count advances once per enabled cycle.
REQ-009 count  output  CNT_W  current count value, registered; consumers use it as a memory address in the same cycle enable is high.
REQ-010 valid  output  1  qualifies count as a usable address in the current cycle.

Function
REQ-011 count SHALL hold its value on every rising edge where enable=0.
REQ-012 When enable=1 and count<NUM_COUNT-1, count SHALL become count+1 at the next rising edge.
REQ-013 When enable=1, count=NUM_COUNT-1 and WRAP=1, count SHALL become 0 at the next rising edge.
REQ-014 When enable=1, count=NUM_COUNT-1 and WRAP=0, count SHALL stay at NUM_COUNT-1 and the internal exhausted flag SHALL set at the next rising edge.
REQ-015 While exhausted=1, count SHALL hold regardless of enable; only reset clears exhausted.
REQ-016 valid SHALL be combinational: valid = enable AND NOT exhausted; with WRAP=1, exhausted is constant 0.
REQ-017 Latency: the first enabled cycle after reset SHALL present count=0 with valid=1; each further enabled cycle presents the next value, with no gaps.
REQ-018 Non-contiguous enable bursts SHALL resume from the held value; the sequence does not restart between bursts.
REQ-019 Increment arithmetic SHALL be CNT_W bits wide; count SHALL never exceed NUM_COUNT-1, even when NUM_COUNT is not a power of two.
REQ-020 There SHALL be no explicit state machine; state is count plus exhausted only.
REQ-021 Elaboration SHALL fail (assertion or $error) if NUM_COUNT<2 or WRAP is not 0 or 1.

Reset
REQ-022 reset=0 SHALL immediately, without waiting for a clock, force count=0 and exhausted=0; valid then follows enable.
REQ-023 Reset asserted mid-sequence SHALL abandon the sequence; after release, counting restarts at 0.
REQ-024 Reset release SHALL be synchronous to clk in the integrating design; the block adds no synchronizer.

Structure
REQ-025 No shared package SHALL be required; CNT_W stays local to the module.
REQ-026 The block SHALL be a single leaf module with no sub-modules: one always_ff for count/exhausted and one continuous assign for valid.

Verification
REQ-027 NUM_COUNT=100, WRAP=1; reset, then enable high for 5 cycles -> count 0,1,2,3,4 with valid=1 each cycle, then holds at 5 with valid=0.
REQ-028 NUM_COUNT=100, WRAP=1; enable for 3 cycles, low for 4, high for 2 -> count 0,1,2, holds at 3, then 3,4.
REQ-029 NUM_COUNT=100, WRAP=1; enable for 101 cycles -> count reaches 99, next enabled cycle shows 0.
REQ-030 NUM_COUNT=5, WRAP=0; enable for 8 cycles -> count 0..4 with valid=1, then count holds at 4 with valid=0.
REQ-031 NUM_COUNT=100; count at 37, assert reset between clock edges -> count=0 immediately; after release, first enabled cycle shows 0.
REQ-032 NUM_COUNT=6 (non-power-of-two); enable for 7 cycles -> count never shows 6 or 7; sequence 0..5, then 0.
